// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator: relation opcodes,
// controller states and the relation-select function.
package cmp_pkg;

    localparam logic [2:0] OP_LT = 3'd0;
    localparam logic [2:0] OP_LE = 3'd1;
    localparam logic [2:0] OP_EQ = 3'd2;
    localparam logic [2:0] OP_NE = 3'd3;
    localparam logic [2:0] OP_GT = 3'd4;
    localparam logic [2:0] OP_GE = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Map the raw flags to the selected relation; reserved opcodes give 0.
    function automatic logic rel_result(input logic [2:0] op,
                                        input logic       lt,
                                        input logic       eq,
                                        input logic       gt);
        logic r;
        r = 1'b0;
        case (op)
            OP_LT:   r = lt;
            OP_LE:   r = lt | eq;
            OP_EQ:   r = eq;
            OP_NE:   r = ~eq;
            OP_GT:   r = gt;
            OP_GE:   r = gt | eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational CHUNK-bit magnitude compare. flip_i inverts the MSB of
// both operands so a signed top chunk can reuse the unsigned compare.
module cmp_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             flip_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    // Optional sign-bit inversion followed by an unsigned compare.
    always_comb begin
        a_m  = a_i ^ (flip_i ? MSB_MASK : '0);
        b_m  = b_i ^ (flip_i ? MSB_MASK : '0);
        lt_o = (a_m < b_m);
        eq_o = (a_m == b_m);
        gt_o = (a_m > b_m);
    end

endmodule

// File: rtl/iter_compare.sv
// Iterative magnitude comparator: walks the operands CHUNK bits per cycle
// from the MSB and stops at the first differing chunk.
// Optional feature macro: ITER_COMPARE_SIGNED_EN enables the signed mode
// selected by sgn; without it sgn is ignored and all compares are unsigned.
module iter_compare
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic             o,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [2:0]       op_q, op_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, o_q, o_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [CHUNK-1:0] xa, yb;
    logic             flip;
    logic             s_lt, s_eq, s_gt;

`ifdef ITER_COMPARE_SIGNED_EN
    logic             sgn_q, sgn_d;

    // Sign inversion applies to the top chunk only.
    always_comb begin
        flip = sgn_q && (cnt_q == '0);
    end
`else
    logic             unused_sgn;

    assign unused_sgn = sgn;

    // Unsigned-only build: no sign inversion.
    always_comb begin
        flip = 1'b0;
    end
`endif

    // Chunk mux: cnt 0 selects the most significant chunk.
    always_comb begin
        xa = '0;
        yb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(NCHUNK - 1 - i)) begin
                xa = x_q[i*CHUNK +: CHUNK];
                yb = y_q[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i    (xa),
        .b_i    (yb),
        .flip_i (flip),
        .lt_o   (s_lt),
        .eq_o   (s_eq),
        .gt_o   (s_gt)
    );

    // Next-state, operand capture and result update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        o_d     = o_q;
`ifdef ITER_COMPARE_SIGNED_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    op_d    = op;
`ifdef ITER_COMPARE_SIGNED_EN
                    sgn_d   = sgn;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!s_eq) begin
                    lt_d    = s_lt;
                    eq_d    = 1'b0;
                    gt_d    = s_gt;
                    o_d     = rel_result(op_q, s_lt, 1'b0, s_gt);
                    state_d = DONE;
                end else if (cnt_q == CW'(NCHUNK - 1)) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    o_d     = rel_result(op_q, 1'b0, 1'b1, 1'b0);
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ITER_COMPARE_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ITER_COMPARE_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_iter_compare.sv
// Bench for iter_compare (WIDTH=16, CHUNK=4): directed scenarios plus
// randomized compares against an arithmetic reference model.
module tb_iter_compare;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x, y;
    logic [2:0]       op;
    logic             sgn;
    logic             busy, done, o, lt, eq, gt;

    int n_vec = 0;
    int n_err = 0;

    // expected results of the compare in flight
    bit e_lt, e_eq, e_gt, e_o;
    int e_lat;

    iter_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .op    (op),
        .sgn   (sgn),
        .busy  (busy),
        .done  (done),
        .o     (o),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic compare; latency from first differing chunk.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] opv, input logic s);
        bit s_eff;
        int k;
        bit found;
`ifdef ITER_COMPARE_SIGNED_EN
        s_eff = s;
`else
        s_eff = 1'b0;
        if (s) s_eff = 1'b0;
`endif
        if (s_eff) begin
            e_lt = ($signed(a) < $signed(b));
            e_gt = ($signed(a) > $signed(b));
        end else begin
            e_lt = (a < b);
            e_gt = (a > b);
        end
        e_eq = (a == b);
        case (opv)
            3'd0: e_o = e_lt;
            3'd1: e_o = e_lt | e_eq;
            3'd2: e_o = e_eq;
            3'd3: e_o = ~e_eq;
            3'd4: e_o = e_gt;
            3'd5: e_o = e_gt | e_eq;
            default: e_o = 1'b0;
        endcase
        k = NCHUNK - 1;
        found = 1'b0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (!found && (a[(NCHUNK-1-i)*CHUNK +: CHUNK] != b[(NCHUNK-1-i)*CHUNK +: CHUNK])) begin
                k = i;
                found = 1'b1;
            end
        end
        e_lat = k + 2;
    endtask

    // Issue one compare (called #1 after an edge) and check it through done.
    // Returns #1 after the edge that raised done, with start low.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] opv, input logic s, input bit hold);
        int cyc;
        model(a, b, opv, s);
        x = a; y = b; op = opv; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        x = ~a; y = ~b; op = 3'd7; sgn = ~s;   // operands must already be latched
        cyc = 1;
        while (!done && cyc < 20) begin
            chk("busy_in_run", busy, 1);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, e_lat);
        chk("busy_at_done", busy, 0);
        chk("o", o, e_o);
        chk("lt", lt, e_lt);
        chk("eq", eq, e_eq);
        chk("gt", gt, e_gt);
    endtask

    // One idle cycle after a done: pulse must drop, results must hold.
    task automatic idle_after;
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("hold_o", o, e_o);
        chk("hold_flags", {lt, eq, gt}, {e_lt, e_eq, e_gt});
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; op = '0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, o, lt, eq, gt}, 6'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", {busy, done}, 2'b0);

        // LT, all chunks examined
        run_cmp(16'h1234, 16'h1235, 3'd0, 1'b0, 1'b0);
        chk("tp1_lat", e_lat, 5);
        idle_after();

        // top-chunk difference, unsigned then signed request
        run_cmp(16'h8000, 16'h0001, 3'd4, 1'b0, 1'b0);
        idle_after();
        run_cmp(16'h8000, 16'h0001, 3'd4, 1'b1, 1'b0);
        idle_after();

        // equality, EQ then NE
        run_cmp(16'hABCD, 16'hABCD, 3'd2, 1'b0, 1'b0);
        idle_after();
        run_cmp(16'hABCD, 16'hABCD, 3'd3, 1'b0, 1'b0);
        idle_after();

        // start held through RUN is ignored
        run_cmp(16'h1234, 16'h1235, 3'd1, 1'b0, 1'b1);
        idle_after();

        // back-to-back: second start taken in the DONE cycle
        run_cmp(16'h5000, 16'h4FFF, 3'd5, 1'b0, 1'b0);
        run_cmp(16'h1234, 16'h1244, 3'd0, 1'b0, 1'b0);
        idle_after();

        // reserved op
        run_cmp(16'h0010, 16'h0020, 3'd6, 1'b0, 1'b0);
        idle_after();
        // sgn with negative operand
        run_cmp(16'hFFFF, 16'h0001, 3'd4, 1'b1, 1'b0);
        idle_after();

        // reset in cycle 2 of a long compare
        x = 16'h1234; y = 16'h1235; op = 3'd0; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outs", {busy, done, o, lt, eq, gt}, 6'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {busy, done}, 2'b0);
        end

        // randomized compares with chunk-level perturbations and random chaining
        for (int t = 0; t < 60; t++) begin
            ra = WIDTH'($urandom);
            rb = ra;
            if ($urandom_range(0, 5) != 0)
                rb[$urandom_range(0, NCHUNK-1)*CHUNK +: CHUNK] = CHUNK'($urandom);
            if ($urandom_range(0, 3) == 0)
                rb = WIDTH'($urandom);
            run_cmp(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
